// File: rtl/pos_sweep_pkg.sv
// Shared types and helpers for the product-of-sums truth-table sweeper.
// Optional feature macro: POS_ONES_COUNT_EN (adds a running count of true minterms).
package pos_sweep_pkg;

  localparam int unsigned N_MAX       = 8;
  localparam int unsigned CLAUSES_MAX = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

  // Width of the truth table for n inputs.
  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/pos_sweep_eval_if.sv
// Control/result bundle between a requester and the pos_sweep_eval engine.
// Optional feature macro: POS_ONES_COUNT_EN (adds ones_cnt).
interface pos_sweep_eval_if
  import pos_sweep_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned CLAUSES = 3
) ();

  logic                     start;
  logic [CLAUSES*N-1:0]     pos_mask;
  logic [CLAUSES*N-1:0]     neg_mask;
  logic [CLAUSES-1:0]       clause_en;
  logic                     busy;
  logic [N-1:0]             m;
  logic                     s;
  logic                     valid;
  logic [tt_width(N)-1:0]   tt;
  logic                     done;
`ifdef POS_ONES_COUNT_EN
  logic [N:0]               ones_cnt;
`endif

  modport master (
    output start, pos_mask, neg_mask, clause_en,
`ifdef POS_ONES_COUNT_EN
    input  ones_cnt,
`endif
    input  busy, m, s, valid, tt, done
  );

  modport slave (
    input  start, pos_mask, neg_mask, clause_en,
`ifdef POS_ONES_COUNT_EN
    output ones_cnt,
`endif
    output busy, m, s, valid, tt, done
  );

endinterface

// File: rtl/pos_clause_eval.sv
// One product-of-sums clause: OR of the selected literals of minterm m.
// An empty clause is 0; a disabled clause is 1 so it drops out of the AND.
module pos_clause_eval #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] i_m,
  input  logic [N-1:0] i_pos,
  input  logic [N-1:0] i_neg,
  input  logic         i_en,
  output logic         o_clause
);

  logic w_any_lit;

  // Literal x_i is true when m[i] = 1, literal ~x_i when m[i] = 0.
  always_comb begin
    w_any_lit = |((i_m & i_pos) | (~i_m & i_neg));
    o_clause  = ~i_en | w_any_lit;
  end

endmodule

// File: rtl/pos_sweep_eval.sv
// Sweeps every minterm of an N-input product-of-sums function, one per clock,
// building the full truth table and pulsing done after the last minterm.
// Optional feature macro: POS_ONES_COUNT_EN (running count of true minterms).
module pos_sweep_eval
  import pos_sweep_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned CLAUSES = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  pos_sweep_eval_if.slave   io_bus
);

  localparam int unsigned  TtW  = tt_width(N);
  localparam logic [N-1:0] MMax = '1;

  if (N == 0 || N > N_MAX) begin : g_bad_n
    $error("pos_sweep_eval: N out of range 1..8");
  end
  if (CLAUSES == 0 || CLAUSES > CLAUSES_MAX) begin : g_bad_clauses
    $error("pos_sweep_eval: CLAUSES out of range 1..8");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic [N-1:0]         r_m;
  logic [TtW-1:0]       r_tt;
  logic [CLAUSES*N-1:0] r_pos;
  logic [CLAUSES*N-1:0] r_neg;
  logic [CLAUSES-1:0]   r_en;
  logic [CLAUSES-1:0]   w_clause;
  logic                 w_s;

  for (genvar k = 0; k < CLAUSES; k++) begin : g_clause
    pos_clause_eval #(
      .N (N)
    ) u_clause (
      .i_m      (r_m),
      .i_pos    (r_pos[k*N +: N]),
      .i_neg    (r_neg[k*N +: N]),
      .i_en     (r_en[k]),
      .o_clause (w_clause[k])
    );
  end

  assign w_s = &w_clause;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; start is only honoured outside RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_state_nxt = StRun;
          w_accept    = 1'b1;
        end
      end
      StRun: begin
        if (r_m == MMax) w_state_nxt = StDone;
      end
      StDone: begin
        if (io_bus.start) begin
          w_state_nxt = StRun;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Mask latches, minterm counter and truth-table write; m wraps to 0 on the last minterm.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_m   <= '0;
      r_tt  <= '0;
      r_pos <= '0;
      r_neg <= '0;
      r_en  <= '0;
    end else if (w_accept) begin
      r_m   <= '0;
      r_tt  <= '0;
      r_pos <= io_bus.pos_mask;
      r_neg <= io_bus.neg_mask;
      r_en  <= io_bus.clause_en;
    end else if (r_state == StRun) begin
      r_tt[r_m] <= w_s;
      r_m       <= r_m + N'(1);
    end
  end

`ifdef POS_ONES_COUNT_EN
  logic [N:0] r_ones;

  // Running popcount of the truth table being built.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ones <= '0;
    end else if (w_accept) begin
      r_ones <= '0;
    end else if (r_state == StRun) begin
      r_ones <= r_ones + (N+1)'(w_s);
    end
  end

  assign io_bus.ones_cnt = r_ones;
`endif

  assign io_bus.busy  = (r_state == StRun);
  assign io_bus.valid = (r_state == StRun);
  assign io_bus.done  = (r_state == StDone);
  assign io_bus.m     = r_m;
  assign io_bus.s     = w_s;
  assign io_bus.tt    = r_tt;

endmodule
